// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Parametrised elastic pipeline register. Carries a packed payload through
//   DEPTH register stages under a valid/ready handshake, with synchronous
//   flush and either bubble-collapsing (COLLAPSE=1) or lockstep (COLLAPSE=0)
//   stall behaviour. Callers pack their control and data fields into in_data.
//
// Parameters
//   DATA_W   payload width (1..256)
//   DEPTH    number of register stages (1..4)
//   COLLAPSE 1 = empty stages fill while downstream stalls, 0 = lockstep
//   RST_VAL  payload value loaded by reset
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-high (wins over flush)
//   in_valid   upstream payload present
//   in_ready   payload accepted this cycle (combinational)
//   in_data    upstream payload
//   flush      clears every stage valid bit this cycle (wins over advance)
//   out_valid  last stage valid (registered)
//   out_ready  downstream consumes this cycle
//   out_data   last stage payload (registered)
//   occupancy  count of valid stages, only when PIPE_STAGE_OCC_EN is defined
//
// Optional feature macro: PIPE_STAGE_OCC_EN

module pipe_stage_elastic #(
  parameter int unsigned         DATA_W   = 44,
  parameter int unsigned         DEPTH    = 1,
  parameter bit                  COLLAPSE = 1'b1,
  parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_OCC_EN
  ,
  output logic [2:0]        occupancy
`endif
);

  logic [DEPTH-1:0]  v_q;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DEPTH-1:0]  adv;
  logic              full_run;
  logic              in_xfer;
  logic              out_xfer;

  // Advance enables. In collapse mode a stage may move when any stage at or
  // beyond it is empty or the sink drains; this is the unrolled form of
  // adv[i] = ~v[i] | adv[i+1], built with a running AND to avoid a
  // self-referencing vector.
  always_comb begin
    adv      = '0;
    full_run = 1'b1;
    if (COLLAPSE) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        full_run            = full_run & v_q[DEPTH-1-k];
        adv[DEPTH-1-k]      = out_ready | ~full_run;
      end
    end else begin
      adv = {DEPTH{~v_q[DEPTH-1] | out_ready}};
    end
  end

  assign in_ready  = adv[0] & ~flush & ~rst;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= RST_VAL;
      end
    end else if (flush) begin
      v_q <= '0;
    end else begin
      if (adv[0]) begin
        v_q[0] <= in_xfer;
        if (in_xfer) begin
          d_q[0] <= in_data;
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_q[i] <= v_q[i-1];
          // payload registers only load when a valid entry moves in
          if (v_q[i-1]) begin
            d_q[i] <= d_q[i-1];
          end
        end
      end
    end
  end

`ifdef PIPE_STAGE_OCC_EN
  logic [2:0] occ_q;
  logic [2:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + 3'd1;
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  a_occ_max : assert property (@(posedge clk) disable iff (rst)
    occ_q <= 3'(DEPTH));
  a_occ_underflow : assert property (@(posedge clk) disable iff (rst || flush)
    !(occ_q == '0 && out_xfer && !in_xfer));
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width packed payload through DEPTH register stages with a valid/ready handshake.
- Provides synchronous flush for branch and interrupt squashing, and selectable bubble-collapsing or lockstep stall.
- One instance replaces each hand-written stage latch; callers pack their control and data fields into in_data.

Parameters:
- DATA_W, 44, payload width in bits (1..256).
- DEPTH, 1, number of register stages (1..4).
- COLLAPSE, 1, 1 = an empty stage accepts data even while later stages stall; 0 = lockstep, all stages hold together.
- RST_VAL, 0, payload reset value (DATA_W bits).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream has a payload this cycle.
- in_ready  out  1  block accepts the payload this cycle (combinational).
- in_data  in  DATA_W  upstream payload.
- flush  in  1  squash every stage this cycle.
- out_valid  out  1  last stage holds a valid payload (registered).
- out_ready  in  1  downstream consumes the payload this cycle; low = stall.
- out_data  out  DATA_W  last-stage payload (registered).
- occupancy  out  3  count of valid stages (present only with the optional feature).

Behaviour:
- State: v[i] and d[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_data.
- Reset (rst=1 at posedge): all v=0, all d=RST_VAL, so out_valid=0 and out_data=RST_VAL. While rst=1, in_ready=0.
- Transfer definitions:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Advance enables, COLLAPSE=1:
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - adv[i] = ~v[i] | adv[i+1].
  - in_ready = adv[0] & ~flush & ~rst.
- Advance enables, COLLAPSE=0:
  - All adv[i] = ~v[DEPTH-1] | out_ready.
  - in_ready = adv[0] & ~flush & ~rst.
- Stage update when adv[i]=1:
  - Stage 0 takes v=input transfer; d=in_data only on an input transfer, otherwise d holds.
  - Stage i>0 takes v=v[i-1] and d=d[i-1] (d updates only when v[i-1]=1).
  - Payload registers never load on invalid cycles (power and debug).
- Stage hold: when adv[i]=0, v[i] and d[i] hold. out_data stays stable while out_valid & ~out_ready.
- Latency: with out_ready=1 continuously, a payload accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1. DEPTH=1 gives a one-cycle latch.
- Throughput: one payload per cycle when unstalled.
- Flush (flush=1 at posedge): all v cleared to 0 and d unchanged.
  - Input is refused because in_ready=0.
  - An output transfer in the same cycle still counts as consumed by downstream.
- Simultaneous events:
  - rst has priority over flush, and flush over advance.
  - Full pipe with out_ready=1 and in_valid=1 gives a simultaneous in and out transfer; occupancy is unchanged.
- COLLAPSE=1 bubble fill: while downstream stalls, an empty stage k accepts data from k-1. The pipe can fill to DEPTH entries with no loss.
- COLLAPSE=0: no stage moves while the last stage holds an unconsumed payload, even if bubbles exist. in_ready = ~out_valid | out_ready.
- Reset mid-operation: in-flight payloads are discarded; nothing is emitted after reset deasserts until new input arrives.
- Combinational paths: only in_ready depends combinationally on out_ready/flush/rst. No combinational path exists from in_data to out_data.

Optional Feature:
- Macro PIPE_STAGE_OCC_EN.
- Defined:
  - occupancy port exists and equals the registered count of set v bits (0..DEPTH).
  - Counter updates each edge: +1 on an input transfer, -1 on an output transfer, net 0 when both occur; cleared to 0 on rst or flush.
  - A simulation-only assertion fires if the counter exceeds DEPTH or underflows.
- Undefined: occupancy port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: DEPTH=3, RST_VAL=0; hold rst 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0; after release, nothing is emitted until new input.
- Streaming: DEPTH=3, out_ready=1; feed 0x001..0x00A on consecutive cycles -> outputs 0x001..0x00A in order, first one 2 edges after acceptance, no gaps.
- Stall and fill (COLLAPSE=1): DEPTH=3; hold out_ready=0 and offer 0xA1, 0xA2, 0xA3, 0xA4:
  - Three accepted, then in_ready=0 and occupancy=3.
  - out_data held at 0xA1.
  - On release, the sequence is 0xA1, 0xA2, 0xA3, then 0xA4.
- Lockstep (COLLAPSE=0): DEPTH=2; accept 0x11, idle one cycle, then 0x22 while out_ready=0 -> the bubble is not filled, in_ready=0 while out_valid=1 and out_ready=0, and order is preserved.
- Flush: DEPTH=3 holding 3 valid entries, pulse flush with in_valid=1 data 0x55 -> next cycle out_valid=0 and occupancy=0; 0x55 is never emitted.
- Priority: assert rst and flush together with the pipe full -> state equals post-reset; out_data=RST_VAL.
